// File: rtl/rq_ack_pkg.sv
// Shared definitions for the req/ack slave family (divider and multiplier slaves).
// Contents:
//   state_e          - handshake FSM state encoding
//   operand_width()  - operand width N derived from the request payload width
//   counter_width()  - width of a down-counter that must hold max(N, dispersion)
package rq_ack_pkg;

  localparam int unsigned MaxReqDataWidth = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCalc    = 3'd1,
    StWait    = 3'd2,
    StAck     = 3'd3,
    StRelease = 3'd4
  } state_e;

  function automatic int unsigned operand_width(input int unsigned reqdata_width);
    return reqdata_width / 2;
  endfunction

  function automatic int unsigned counter_width(input int unsigned n,
                                                input int unsigned dispersion);
    int unsigned max_val;
    max_val = (n > dispersion) ? n : dispersion;
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pas_impartire.sv
// One combinational restoring-division step.
// Ports:
//   rem_i      - partial remainder before this step
//   bit_i      - next dividend bit shifted into the remainder
//   divisor_i  - divisor
//   rem_o      - partial remainder after this step
//   quo_bit_o  - quotient bit produced by this step
module pas_impartire #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] rem_i,
  input  logic             bit_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] rem_o,
  output logic             quo_bit_o
);

  logic [Width:0] trial;
  logic [Width:0] dvs_ext;
  logic [Width:0] diff;
  logic [Width:0] rem_sel;
  logic           unused_rem_msb;

  always_comb begin
    trial     = {rem_i, bit_i};
    dvs_ext   = {1'b0, divisor_i};
    diff      = trial - dvs_ext;
    quo_bit_o = (trial >= dvs_ext);
    rem_sel   = quo_bit_o ? diff : trial;
  end

  // When the subtract happens the result is below the divisor, so the MSB is zero.
  // With a zero divisor the MSB falls off, which is what yields remainder = dividend.
  assign rem_o          = rem_sel[Width-1:0];
  assign unused_rem_msb = rem_sel[Width];

endmodule

// File: rtl/impartire_slave_rq_ack.sv
// Sequential restoring-division slave on the req/ack handshake.
// Captures {dividend, divisor} on req, produces one quotient bit per clock and returns
// {quotient, remainder} with a single-cycle ack, optionally delayed by DISPERSION cycles.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   req       - request, held by the master until ack is seen
//   req_data  - {dividend, divisor}
//   ack       - one-cycle response strobe
//   ack_data  - {quotient, remainder}, held until the next result
//   busy      - high from capture until IDLE is re-entered
//   div_zero  - divisor of the current/last operation was zero
module impartire_slave_rq_ack
  import rq_ack_pkg::*;
#(
  parameter int unsigned REQDATA_WIDTH = 16,
  parameter int unsigned ACKDATA_WIDTH = 16,
  parameter int unsigned IMEDIAT       = 1,
  parameter int unsigned DISPERSION    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [REQDATA_WIDTH-1:0] req_data,
  output logic                     ack,
  output logic [ACKDATA_WIDTH-1:0] ack_data,
  output logic                     busy,
  output logic                     div_zero
);

  localparam int unsigned N  = operand_width(REQDATA_WIDTH);
  localparam int unsigned CW = counter_width(N, DISPERSION);
  // DISPERSION = 0 degenerates to immediate ack.
  localparam bit UseWait = (IMEDIAT == 0) && (DISPERSION != 0);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N-1:0]             rem_q, rem_d;
  logic [N-1:0]             quo_q, quo_d;  // dividend bits shift out, quotient bits shift in
  logic [N-1:0]             dvs_q, dvs_d;
  logic                     dz_q, dz_d;
  logic [ACKDATA_WIDTH-1:0] ack_data_q, ack_data_d;
  logic                     ack_q, ack_d;
  logic                     busy_q, busy_d;

  logic [N-1:0]             step_rem;
  logic                     step_bit;
  logic [N-1:0]             quo_shift;

  pas_impartire #(
    .Width (N)
  ) u_pas_impartire (
    .rem_i     (rem_q),
    .bit_i     (quo_q[N-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_bit_o (step_bit)
  );

  assign quo_shift = (quo_q << 1) | N'(step_bit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dz_d       = dz_q;
    ack_data_d = ack_data_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          rem_d   = '0;
          quo_d   = req_data[2*N-1:N];
          dvs_d   = req_data[N-1:0];
          cnt_d   = CW'(N);
          dz_d    = (req_data[N-1:0] == '0);
          state_d = StCalc;
        end
      end

      StCalc: begin
        rem_d = step_rem;
        quo_d = quo_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          if (UseWait) begin
            cnt_d   = CW'(DISPERSION);
            state_d = StWait;
          end else begin
            cnt_d      = '0;
            ack_data_d = ACKDATA_WIDTH'({quo_shift, step_rem});
            state_d    = StAck;
          end
        end
      end

      StWait: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d      = '0;
          ack_data_d = ACKDATA_WIDTH'({quo_q, rem_q});
          state_d    = StAck;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      StAck: begin
        // A request still high here is the one just answered; park until it drops.
        state_d = req ? StRelease : StIdle;
      end

      StRelease: begin
        if (!req) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they are glitch-free ports.
    ack_d  = (state_d == StAck);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dz_q       <= 1'b0;
      ack_data_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dz_q       <= dz_d;
      ack_data_q <= ack_data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign ack_data = ack_data_q;
  assign busy     = busy_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_impartire_slave_rq_ack.sv
module tb_impartire_slave_rq_ack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1;
  logic [15:0] rd0, rd1;
  logic        ack0, ack1;
  logic [15:0] ad0, ad1;
  logic        busy0, busy1;
  logic        dz0, dz1;

  int n_cmp = 0;
  int n_err = 0;

  impartire_slave_rq_ack #(
    .REQDATA_WIDTH (16),
    .ACKDATA_WIDTH (16),
    .IMEDIAT       (1),
    .DISPERSION    (10)
  ) u_imm (
    .clk      (clk),
    .rst      (rst),
    .req      (req0),
    .req_data (rd0),
    .ack      (ack0),
    .ack_data (ad0),
    .busy     (busy0),
    .div_zero (dz0)
  );

  impartire_slave_rq_ack #(
    .REQDATA_WIDTH (16),
    .ACKDATA_WIDTH (16),
    .IMEDIAT       (0),
    .DISPERSION    (10)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .req      (req1),
    .req_data (rd1),
    .ack      (ack1),
    .ack_data (ad1),
    .busy     (busy1),
    .div_zero (dz1)
  );

  // Reference: plain integer division, divisor 0 gives all-ones quotient and dividend remainder.
  function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {8'hFF, a};
    return {8'(a / b), 8'(a % b)};
  endfunction

  // One transaction on DUT sel (0 = immediate, 1 = delayed). Must be called at a negedge.
  task automatic run(input bit sel, input logic [7:0] a, input logic [7:0] b,
                     input bit hold, input bit scramble, input string name);
    logic [15:0] exp;
    int          exp_lat;
    int          lat;
    int          extra;
    bit          got;
    exp     = ref_div(a, b);
    exp_lat = sel ? 18 : 8;
    if (sel) begin req1 = 1'b1; rd1 = {a, b}; end
    else     begin req0 = 1'b1; rd0 = {a, b}; end
    @(posedge clk);  // capture edge
    @(negedge clk);
    n_cmp++;
    if ((sel ? busy1 : busy0) !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_capture got %b want 1", name, sel ? busy1 : busy0);
    end
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((sel ? ack1 : ack0) === 1'b1) got = 1'b1;
      else if (scramble) begin
        if (sel) rd1 = 16'($urandom);
        else     rd0 = 16'($urandom);
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s ack_timeout got no ack in %0d cycles want ack at %0d", name, lat, exp_lat);
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      return;
    end
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if ((sel ? ad1 : ad0) !== exp) begin
      n_err++;
      $display("FAIL %s ack_data got %h want %h (a=%0d b=%0d)", name, sel ? ad1 : ad0, exp, a, b);
    end
    n_cmp++;
    if ((sel ? dz1 : dz0) !== (b == 8'd0)) begin
      n_err++;
      $display("FAIL %s div_zero got %b want %b", name, sel ? dz1 : dz0, b == 8'd0);
    end
    if (hold) begin
      extra = 0;
      repeat (20) begin
        @(posedge clk);
        @(negedge clk);
        if ((sel ? ack1 : ack0) === 1'b1) extra++;
      end
      n_cmp++;
      if (extra != 0 || (sel ? busy1 : busy0) !== 1'b1) begin
        n_err++;
        $display("FAIL %s held_req extra_acks got %0d busy %b want 0 acks busy 1", name, extra,
                 sel ? busy1 : busy0);
      end
    end
    if (sel) req1 = 1'b0;
    else     req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ((sel ? ack1 : ack0) !== 1'b0 || (sel ? busy1 : busy0) !== 1'b0) begin
      n_err++;
      $display("FAIL %s back_to_idle got ack %b busy %b want 0 0", name, sel ? ack1 : ack0,
               sel ? busy1 : busy0);
    end
    n_cmp++;
    if ((sel ? ad1 : ad0) !== exp || (sel ? dz1 : dz0) !== (b == 8'd0)) begin
      n_err++;
      $display("FAIL %s result_held got %h/%b want %h/%b", name, sel ? ad1 : ad0,
               sel ? dz1 : dz0, exp, b == 8'd0);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    rd0  = 16'h0; rd1 = 16'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack0, ad0, busy0, dz0, ack1, ad1, busy1, dz1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %b %h %b %b / %b %h %b %b want all 0",
               ack0, ad0, busy0, dz0, ack1, ad1, busy1, dz1);
    end
    rst = 1'b0;
  endtask

  // Directed cases issued back to back at the minimum interval.
  task automatic test_directed();
    run(1'b0, 8'd100, 8'd7,   1'b0, 1'b0, "div_100_7");
    run(1'b0, 8'd255, 8'd1,   1'b0, 1'b0, "div_255_1");
    run(1'b0, 8'd3,   8'd10,  1'b0, 1'b0, "div_3_10");
    run(1'b0, 8'd200, 8'd200, 1'b0, 1'b0, "div_200_200");
    run(1'b0, 8'd5,   8'd0,   1'b0, 1'b0, "div_5_0");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run(1'b0, a, b, 1'b0, 1'b1, "random_imm");
    end
  endtask

  task automatic test_hold();
    run(1'b0, 8'd77, 8'd9, 1'b1, 1'b0, "hold_req");
    run(1'b0, 8'd100, 8'd7, 1'b0, 1'b0, "after_hold");
  endtask

  task automatic test_reset_abort();
    int acks;
    req0 = 1'b1;
    rd0  = 16'h6407;
    @(posedge clk);          // capture
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    #1;
    n_cmp++;
    if ({ack0, ad0, busy0, dz0} !== '0) begin
      n_err++;
      $display("FAIL reset_abort_outputs got %b %h %b %b want all 0", ack0, ad0, busy0, dz0);
    end
    acks = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL reset_abort_no_ack got %0d acks want 0", acks);
    end
    rst = 1'b0;
    run(1'b0, 8'd100, 8'd7, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_wait();
    logic [7:0] a, b;
    run(1'b1, 8'd100, 8'd7, 1'b0, 1'b1, "wait_100_7");
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      run(1'b1, a, b, 1'b0, 1'b1, "random_wait");
    end
    run(1'b1, 8'd50, 8'd6, 1'b1, 1'b0, "wait_hold");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_abort();
    test_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
